// File: rtl/uart_pkg.sv
// Items shared by the UART receive and transmit blocks.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side output bundle of the UART receiver.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 rx_done;
  logic                 frame_err;
  logic                 busy;

  modport master (output data, rx_done, frame_err, busy);
  modport slave  (input  data, rx_done, frame_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, reset to a chosen idle level.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualify at half period, mid-bit data sampling,
// stop-bit check with break hold-off. Bytes are handed out on a one-cycle rx_done.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CNT_W     = UART_CNT_W,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [CNT_W-1:0] bit_period,
  input  logic             serial_in,
  uart_rx_if.master        rx
);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state, nxt;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt, bp_q;
  logic [CNT_W-1:0]     half_m1, full_m1;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] sreg, data_q;
  logic                 done_q, ferr_q;
  logic                 sample, shift, latch, done_nxt, ferr_nxt;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (serial_in),
    .q    (rx_s)
  );

  assign half_m1 = (bp_q >> 1) - CNT_W'(1);
  assign full_m1 = bp_q - CNT_W'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    sample   = 1'b0;
    shift    = 1'b0;
    latch    = 1'b0;
    done_nxt = 1'b0;
    ferr_nxt = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        nxt   = START;
        latch = 1'b1;
      end
      // A start bit still low at its midpoint is real; otherwise it was a glitch.
      START: if (cnt == half_m1) begin
        sample = 1'b1;
        nxt    = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == full_m1) begin
        sample = 1'b1;
        shift  = 1'b1;
        if (idx == LAST_IDX) nxt = STOP;
      end
      STOP: if (cnt == full_m1) begin
        sample = 1'b1;
        if (rx_s) begin
          done_nxt = 1'b1;
          nxt      = IDLE;
        end else begin
          ferr_nxt = 1'b1;
          nxt      = BREAK;
        end
      end
      // Held-low line must return high before another start is accepted.
      BREAK: if (rx_s) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt    <= '0;
      bp_q   <= '0;
      idx    <= '0;
      sreg   <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (state == IDLE || sample || nxt != state) cnt <= '0;
      else                                         cnt <= cnt + CNT_W'(1);
      if (latch) bp_q <= bit_period;
      if (state == START && sample) idx <= '0;
      else if (shift)               idx <= idx + IDX_W'(1);
      if (shift)    sreg[idx] <= rx_s;
      if (done_nxt) data_q    <= sreg;
      done_q <= done_nxt;
      ferr_q <= ferr_nxt;
    end
  end

  assign rx.data      = data_q;
  assign rx.rx_done   = done_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial stimulus pushes expected bytes/errors,
// a negedge monitor pops and checks them when the DUT pulses.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] bit_period = 16'd16;
  logic        serial_in = 1'b1;

  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx dut (
    .clk        (clk),
    .nrst       (nrst),
    .bit_period (bit_period),
    .serial_in  (serial_in),
    .rx         (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         at;
  } exp_t;

  exp_t done_q[$];
  int   ferr_q[$];
  int   total = 0;
  int   bad = 0;
  logic prev_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    int   fa;
    if (rx_if.rx_done) begin
      if (done_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_done_unexpected: got data %0h at cycle %0d want no pulse", rx_if.data, cyc);
      end else begin
        e = done_q.pop_front();
        check("rx_data", {24'd0, rx_if.data}, {24'd0, e.b});
        check("rx_cycle", cyc, e.at);
      end
      check("done_ferr_overlap", {31'd0, rx_if.frame_err}, 32'd0);
      check("done_back_to_back", {31'd0, prev_done}, 32'd0);
    end
    if (rx_if.frame_err) begin
      if (ferr_q.size() == 0) begin
        total++; bad++;
        $display("FAIL frame_err_unexpected: got pulse at cycle %0d want none", cyc);
      end else begin
        fa = ferr_q.pop_front();
        check("ferr_cycle", cyc, fa);
      end
    end
    prev_done <= rx_if.rx_done;
  end

  // One 8N1 frame, start edge driven just after a clock edge; no gap after stop.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bp, input bit exp);
    logic [9:0] fr;
    int         at;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < bp; k++) begin
        @(posedge clk); #1;
        serial_in = fr[i];
        if (i == 0 && k == 0 && exp) begin
          at = cyc + 3 + (bp >> 1) + 9 * bp;
          if (stop) done_q.push_back('{b, at});
          else      ferr_q.push_back(at);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] b2b [8] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'hC3, 8'h5A};

  initial begin
    int s;
    // Reset state
    idle(3);
    check("rst_data", {24'd0, rx_if.data}, 32'd0);
    check("rst_done", {31'd0, rx_if.rx_done}, 32'd0);
    check("rst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
    check("rst_busy", {31'd0, rx_if.busy}, 32'd0);
    nrst = 1'b1;
    idle(5);

    // Single frame, latency 155 at bp=16
    send_frame(8'h55, 1'b1, 16, 1'b1);
    idle(20);
    check("single_hold", {24'd0, rx_if.data}, 32'h55);

    // Back-to-back frames with no idle gap
    foreach (b2b[i]) send_frame(b2b[i], 1'b1, 16, 1'b1);
    idle(30);
    check("b2b_last", {24'd0, rx_if.data}, 32'h5A);
    check("b2b_idle", {31'd0, rx_if.busy}, 32'd0);

    // Framing error, then line held low as a break
    send_frame(8'hA3, 1'b0, 16, 1'b1);
    idle(20);
    check("brk_busy_a", {31'd0, rx_if.busy}, 32'd1);
    idle(20);
    check("brk_busy_b", {31'd0, rx_if.busy}, 32'd1);
    check("brk_data", {24'd0, rx_if.data}, 32'h5A);
    serial_in = 1'b1;
    idle(5);
    check("brk_release", {31'd0, rx_if.busy}, 32'd0);
    idle(20);

    // 3-cycle glitch from idle
    @(posedge clk); #1;
    serial_in = 1'b0;
    s = cyc;
    repeat (3) @(posedge clk);
    #1 serial_in = 1'b1;
    idle(2);
    check("glitch_busy", {31'd0, rx_if.busy}, 32'd1);
    idle(7);
    check("glitch_cycle", cyc, s + 12);
    check("glitch_idle", {31'd0, rx_if.busy}, 32'd0);
    idle(30);

    // Reset during data bit 4 of 0xFF
    fork
      send_frame(8'hFF, 1'b1, 16, 1'b0);
      begin
        idle(5 * 16 + 8);
        nrst = 1'b0;
        @(negedge clk);
        check("mrst_data", {24'd0, rx_if.data}, 32'd0);
        check("mrst_busy", {31'd0, rx_if.busy}, 32'd0);
        check("mrst_done", {31'd0, rx_if.rx_done}, 32'd0);
        check("mrst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
        idle(5);
        nrst = 1'b1;
      end
    join
    idle(10);
    send_frame(8'h3C, 1'b1, 16, 1'b1);
    idle(20);
    check("mrst_after", {24'd0, rx_if.data}, 32'h3C);

    // Long odd period; a mid-frame bit_period change must be ignored
    bit_period = 16'd1001;
    fork
      send_frame(8'h41, 1'b1, 1001, 1'b1);
      begin
        idle(2000);
        bit_period = 16'd16;
      end
    join
    idle(30);
    check("long_data", {24'd0, rx_if.data}, 32'h41);

    check("done_q_empty", done_q.size(), 32'd0);
    check("ferr_q_empty", ferr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout: got no finish by cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
